sort_seq_ctrl: RTL and testbench
================================

Name: sort_seq_ctrl

Overview:
- Sequential sort controller: collects NUM_VALS unsigned values over a valid/ready input stream and sorts them in place in a register buffer.
- Sorting uses odd-even transposition, one compare-exchange layer per cycle.
- Streams the result out largest-first over a valid/ready output stream.
- Serial, area-lean counterpart to the team's fully combinational descending sorter; used where values arrive one per cycle from a bus.

Parameters:
- NUM_VALS, 8, number of values per sort job; even, >= 2.
- WIDTH, 4, bits per value; unsigned.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  value to load.
- out_valid  output  1  out_data is valid this cycle.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  WIDTH  sorted value, largest first.
- out_last  output  1  marks the final (smallest) value of the job.
- busy  output  1  high in SORT and OUT states.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- States:
  - LOAD: in_ready=1, out_valid=0.
  - SORT: in_ready=0, out_valid=0.
  - OUT: in_ready=0, out_valid=1.
- Reset values: state=LOAD, in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0, counters=0, buffer=0.
- Reset mid-job discards all loaded, sorted or pending data. The next job starts clean.
- LOAD:
  - Each handshake (in_valid & in_ready) writes in_data to buf[cnt], then cnt++.
  - On the handshake with cnt==NUM_VALS-1: cnt clears and the block moves to SORT on the next cycle.
  - in_valid low leaves everything held; gaps are allowed.
- SORT runs exactly NUM_VALS cycles; pass counter p runs 0..NUM_VALS-1.
  - Even p: compare pairs (0,1),(2,3),...
  - Odd p: compare pairs (1,2),(3,4),...; elements 0 and NUM_VALS-1 untouched.
  - Swap when buf[k] < buf[k+1] (unsigned), so larger values move to lower index.
  - Equal values never swap.
  - After pass NUM_VALS-1 the block moves to OUT with idx=0.
- OUT:
  - out_data=buf[idx]; out_last=(idx==NUM_VALS-1).
  - On out_valid & out_ready: idx++.
  - On the handshake with out_last=1: move to LOAD, idx=0.
  - Without out_ready, out_data and out_last hold stable (no drop, no change).
- Latency: last input handshake at cycle t gives first out_valid at t+NUM_VALS+1. Full job = NUM_VALS load + NUM_VALS sort + NUM_VALS out cycles minimum.
- in_valid asserted outside LOAD is ignored (in_ready=0); no data is consumed.
- Input and output phases never overlap, so no simultaneous in/out handshake is possible.
- busy = (state != LOAD).
- Counter widths: $clog2(NUM_VALS). Counters never wrap silently; they clear at the terminal count.

Decomposition:
- Shared package sort_pkg:
  - State enum {LOAD, SORT, OUT}, 2 bits.
  - Localparam CNT_W = $clog2(NUM_VALS), computed per instance.
- Sub-module sort_oet_layer: combinational, parameters NUM_VALS and WIDTH, inputs flat vector and odd/even phase bit, output flat vector after one compare-exchange layer. Uses the same flat packing as the team's sorter: element 0 in the MSB slice.
- Controller holds the buffer, counters and FSM, and instantiates one sort_oet_layer.

Test Plan:
- Basic, default params: load 3,7,1,15,0,9,9,4 back-to-back -> outputs 15,9,9,7,4,3,1,0. out_last only on the 0. First out_valid 9 cycles after the last input handshake.
- Already sorted descending (15..8) and ascending (0..7) inputs -> outputs 15..8 and 7..0. Exactly NUM_VALS SORT cycles in both cases.
- All equal (5 x8) -> eight 5s. Buffer contents unchanged across SORT, confirming no swaps on equality.
- Backpressure and gaps:
  - Random in_valid gaps during load -> correct capture.
  - out_ready low for 3 cycles mid-stream -> out_data and out_last stable.
  - in_valid held high during SORT/OUT -> no extra data consumed.
- Reset mid-job: assert rst after 4 loads, then load a fresh set 2,2,8,1,0,6,3,5 -> outputs 8,6,5,3,2,2,1,0. The pre-reset values never appear.
- Back-to-back jobs: second job loads right after the first job's last output handshake -> in_ready=1 the cycle after out_last accepted, and both jobs sort correctly.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types for the sequential odd-even transposition sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/sort_oet_layer.sv
// One odd-even transposition layer: compare-exchange on even or odd pairs,
// larger value to the lower index. Element 0 lives in the MSB slice.
module sort_oet_layer #(
  parameter int NUM_VALS = 8,
  parameter int WIDTH    = 4
) (
  input  logic [NUM_VALS*WIDTH-1:0] vec_in,
  input  logic                      odd,
  output logic [NUM_VALS*WIDTH-1:0] vec_out
);

  logic [WIDTH-1:0] v [NUM_VALS];
  logic [WIDTH-1:0] r [NUM_VALS];

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    vec_out = '0;
    for (int i = 0; i < NUM_VALS; i++) begin
      v[i] = vec_in[(NUM_VALS-1-i)*WIDTH +: WIDTH];
    end
    r = v;
    // Strict less-than: equal neighbours never move, so the layer is stable.
    for (int k = 0; k < NUM_VALS - 1; k++) begin
      if ((((k % 2) == 1) == odd) && (v[k] < v[k+1])) begin
        r[k]   = v[k+1];
        r[k+1] = v[k];
      end
    end
    for (int i = 0; i < NUM_VALS; i++) begin
      vec_out[(NUM_VALS-1-i)*WIDTH +: WIDTH] = r[i];
    end
  end

endmodule

// File: rtl/sort_seq_ctrl.sv
// Sequential sort controller: load NUM_VALS values, run NUM_VALS transposition
// passes in place, then stream the result out largest-first.
module sort_seq_ctrl #(
  parameter int NUM_VALS = 8,
  parameter int WIDTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  import sort_pkg::*;

  localparam int                CNT_W = (NUM_VALS > 1) ? $clog2(NUM_VALS) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_VALS - 1);

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, pass, idx;
  logic [NUM_VALS*WIDTH-1:0] vals, layer_out;

  // Pass parity selects the even or odd pair set.
  sort_oet_layer #(
    .NUM_VALS (NUM_VALS),
    .WIDTH    (WIDTH)
  ) u_layer (
    .vec_in  (vals),
    .odd     (pass[0]),
    .vec_out (layer_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_valid && cnt == LAST)  state_nxt = SORT;
      SORT:    if (pass == LAST)             state_nxt = OUT;
      OUT:     if (out_ready && idx == LAST) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // NOTE: the value buffer is reset too, so a job aborted by rst can never leak old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vals <= '0;
      cnt  <= '0;
      pass <= '0;
      idx  <= '0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          for (int i = 0; i < NUM_VALS; i++) begin
            if (cnt == CNT_W'(i)) vals[(NUM_VALS-1-i)*WIDTH +: WIDTH] <= in_data;
          end
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        SORT: begin
          vals <= layer_out;
          pass <= (pass == LAST) ? '0 : pass + 1'b1;
        end
        OUT: if (out_ready) idx <= (idx == LAST) ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      LOAD: in_ready = 1'b1;
      OUT: begin
        out_valid = 1'b1;
        out_last  = (idx == LAST);
        for (int i = 0; i < NUM_VALS; i++) begin
          if (idx == CNT_W'(i)) out_data = vals[(NUM_VALS-1-i)*WIDTH +: WIDTH];
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != LOAD);

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Self-checking bench for sort_seq_ctrl: directed jobs plus randomized jobs
// checked against a queue-sort reference model.
module tb_sort_seq_ctrl;

  localparam int N = 8;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [W-1:0] in_data, out_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sort_seq_ctrl #(.NUM_VALS(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_out_data"},  out_data,  0);
  endtask

  task automatic send(input logic [W-1:0] v);
    bit rdy;
    int guard = 0;
    in_valid = 1'b1;
    in_data  = v;
    do begin
      rdy = in_ready;
      tick();
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic load_job(input int vals[N], input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      send(W'(vals[i]));
    end
  endtask

  // Reference: sort the job descending; check latency, SORT length, stream and handshakes.
  task automatic expect_out(input int vals[N], input bit hold_in, input int stall_at, input string tag);
    int q[$];
    int t0, sort_cyc, guard;
    logic [W-1:0] d;
    logic l;
    foreach (vals[i]) q.push_back(vals[i]);
    q.rsort();
    t0 = cyc; sort_cyc = 0; guard = 0;
    if (hold_in) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
    end
    while (!out_valid && guard < 100) begin
      if (busy) sort_cyc++;
      tick();
      guard++;
    end
    check({tag, "_latency"}, cyc - t0, N);
    check({tag, "_sort_cycles"}, sort_cyc, N);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        d = out_data;
        l = out_last;
        repeat (3) begin
          tick();
          check({tag, "_stall_valid"}, out_valid, 1);
          check({tag, "_stall_data"},  out_data,  d);
          check({tag, "_stall_last"},  out_last,  l);
        end
        out_ready = 1'b1;
      end
      check({tag, "_data"}, out_data, q[i]);
      check({tag, "_last"}, out_last, (i == N - 1) ? 1 : 0);
      if (hold_in) check({tag, "_no_accept"}, in_ready, 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_ready_after"}, in_ready, 1);
    check({tag, "_busy_after"},  busy,     0);
  endtask

  initial begin
    int job[N];
    int job2[N];

    do_reset();
    check_idle("reset");

    job = '{3, 7, 1, 15, 0, 9, 9, 4};
    load_job(job, 1'b0);
    expect_out(job, 1'b0, -1, "basic");

    job = '{15, 14, 13, 12, 11, 10, 9, 8};
    load_job(job, 1'b0);
    expect_out(job, 1'b0, -1, "desc");

    job = '{0, 1, 2, 3, 4, 5, 6, 7};
    load_job(job, 1'b0);
    expect_out(job, 1'b0, -1, "asc");

    job = '{5, 5, 5, 5, 5, 5, 5, 5};
    load_job(job, 1'b0);
    expect_out(job, 1'b0, -1, "equal");

    job = '{12, 3, 3, 8, 14, 0, 6, 11};
    load_job(job, 1'b1);
    expect_out(job, 1'b1, 3, "gaps_stall");

    for (int i = 0; i < 4; i++) send(W'(15 - i));
    do_reset();
    check_idle("midreset");
    job = '{2, 2, 8, 1, 0, 6, 3, 5};
    load_job(job, 1'b0);
    expect_out(job, 1'b0, -1, "after_reset");

    foreach (job[i])  job[i]  = $urandom_range(0, 15);
    foreach (job2[i]) job2[i] = $urandom_range(0, 15);
    load_job(job, 1'b0);
    expect_out(job, 1'b0, -1, "b2b_first");
    load_job(job2, 1'b0);
    expect_out(job2, 1'b0, -1, "b2b_second");

    for (int j = 0; j < 25; j++) begin
      foreach (job[i]) job[i] = $urandom_range(0, 15);
      load_job(job, 1'($urandom_range(0, 1)));
      expect_out(job, 1'($urandom_range(0, 1)), $urandom_range(0, N) - 1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
